// File: rtl/ed_result_packer.sv
// Purpose : packs serial 1-bit energy-detection decisions LSB-first into WORD_W-bit
//           words and writes them to the output FIFO; flushes a zero-padded partial
//           word at end of run, then pulses done.
// Latency : the bit that completes a word is accepted at edge t; push_fout is high in
//           the cycle after t when fout_full=0.
// Backpressure: one hold register buffers a completed word while fout_full=1. The
//           shift register keeps filling. dec_ready drops only when the shift register
//           holds WORD_W-1 bits and hold is still occupied. A decision offered while
//           dec_ready=0 is dropped and sets the sticky overflow flag.
//
// Ports:
//   clock, reset            rising-edge clock; asynchronous active-high reset
//   dec_valid/dec_bit       decision stream in; dec_ready = packer can accept
//   end_sig                 one-cycle end-of-run pulse, starts a flush
//   fout_full               output FIFO full
//   push_fout/fout_data     output FIFO write strobe and word
//   word_count              data words pushed since reset or the last done
//   overflow                sticky: a decision was dropped
//   busy/done               FSM not idle / one-cycle completion pulse
//
// Optional build macro PACK_TRAILER_EN: after the flush, a trailer word is pushed.
// The trailer holds {word_count, valid bits in the last data word} and is sent before done.

module ed_result_packer #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic              dec_bit,
    output logic              dec_ready,
    input  logic              end_sig,
    input  logic              fout_full,
    output logic              push_fout,
    output logic [WORD_W-1:0] fout_data,
    output logic [CNT_W-1:0]  word_count,
    output logic              overflow,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(WORD_W);
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);

`ifdef PACK_TRAILER_EN
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FILL    = 3'd1,
        S_FLUSH   = 3'd2,
        S_DONE    = 3'd3,
        S_TRAILER = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_FLUSH = 3'd2,
        S_DONE  = 3'd3
    } state_t;
`endif

    state_t state, state_next;

    logic [WORD_W-1:0] shift_reg;
    logic [CW-1:0]     bit_cnt;
    logic [WORD_W-1:0] hold_data;
    logic              hold_valid;

    logic              accept;
    logic              word_load;
    logic              flush_load;
    logic              flush_exit;
    logic              hold_free;
    logic [WORD_W-1:0] shift_ins;

`ifdef PACK_TRAILER_EN
    // Valid bits in the most recent data word of this run (0 = no data word yet)
    logic [7:0]        last_bits;
    logic [WORD_W-1:0] trailer_word;
`endif

    // ------------------------------------------------------------------
    // Handshake and datapath control
    // ------------------------------------------------------------------
    // dec_ready is a function of registered state only. This keeps the upstream
    // valid->ready path free of combinational loops.
    assign dec_ready = !((bit_cnt == LAST_BIT) && hold_valid)
                       && ((state == S_IDLE) || (state == S_FILL));
    assign accept    = dec_valid & dec_ready;
    assign push_fout = hold_valid & !fout_full;
    assign fout_data = hold_data;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    // The hold register can take a new word if it is empty or is being emptied this edge.
    assign hold_free = !hold_valid || push_fout;

    // The word completes when the last bit position is filled.
    assign word_load  = accept && (bit_cnt == LAST_BIT);
    // A partial word exists only when bit_cnt > 0. A word completed by a bit that
    // arrives with end_sig has already gone to hold, and bit_cnt is 0 again.
    assign flush_load = (state == S_FLUSH) && (bit_cnt != '0) && hold_free;
    // The flush is finished once no partial bits remain and hold has drained.
    assign flush_exit = (state == S_FLUSH) && (bit_cnt == '0) && !hold_valid;

    always_comb begin
        shift_ins          = shift_reg;
        shift_ins[bit_cnt] = dec_bit;
    end

`ifdef PACK_TRAILER_EN
    always_comb begin
        trailer_word = {(WORD_W - 8)'(word_count), last_bits};
    end
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                // end_sig takes priority. A bit accepted in the same cycle is
                // still shifted in and is then flushed.
                if (end_sig) begin
                    state_next = S_FLUSH;
                end else if (accept) begin
                    state_next = S_FILL;
                end
            end
            S_FILL: begin
                if (end_sig) begin
                    state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (flush_exit) begin
`ifdef PACK_TRAILER_EN
                    state_next = S_TRAILER;
`else
                    state_next = S_DONE;
`endif
                end
            end
`ifdef PACK_TRAILER_EN
            S_TRAILER: begin
                // Hold contains only the trailer in this state, so its push ends the run.
                if (push_fout) begin
                    state_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shift register and bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (word_load || flush_load) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (accept) begin
            shift_reg <= shift_ins;
            bit_cnt   <= bit_cnt + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Hold register: a load takes priority over a simultaneous push, so
    // hold_valid stays set when a new word arrives on the drain edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else if (word_load) begin
            hold_data  <= shift_ins;
            hold_valid <= 1'b1;
        end else if (flush_load) begin
            hold_data  <= shift_reg;  // upper bits are already zero
            hold_valid <= 1'b1;
`ifdef PACK_TRAILER_EN
        end else if (flush_exit) begin
            hold_data  <= trailer_word;
            hold_valid <= 1'b1;
`endif
        end else if (push_fout) begin
            hold_valid <= 1'b0;
        end
    end

`ifdef PACK_TRAILER_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_bits <= '0;
        end else if (state == S_DONE) begin
            last_bits <= '0;
        end else if (word_load) begin
            last_bits <= 8'(WORD_W);
        end else if (flush_load) begin
            last_bits <= 8'(bit_cnt);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Status: word counter and sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_count <= '0;
        end else if (state == S_DONE) begin
            word_count <= '0;
`ifdef PACK_TRAILER_EN
        end else if (push_fout && (state != S_TRAILER)) begin
`else
        end else if (push_fout) begin
`endif
            word_count <= word_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (dec_valid && !dec_ready) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ed_result_packer.sv
// Directed bench for ed_result_packer (WORD_W=32). Expected words go into a queue
// when the stimulus is driven. A monitor pops one entry for each push_fout.
module tb_ed_result_packer;

    localparam int W  = 32;
    localparam int CN = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          dec_valid = 1'b0;
    logic          dec_bit = 1'b0;
    logic          end_sig = 1'b0;
    logic          fout_full = 1'b0;
    logic          dec_ready;
    logic          push_fout;
    logic [W-1:0]  fout_data;
    logic [CN-1:0] word_count;
    logic          overflow;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_pass   = 0;
    int push_cnt = 0;
    logic [W-1:0] exp_q[$];

    ed_result_packer #(.WORD_W(W), .CNT_W(CN)) dut (
        .clock      (clock),
        .reset      (reset),
        .dec_valid  (dec_valid),
        .dec_bit    (dec_bit),
        .dec_ready  (dec_ready),
        .end_sig    (end_sig),
        .fout_full  (fout_full),
        .push_fout  (push_fout),
        .fout_data  (fout_data),
        .word_count (word_count),
        .overflow   (overflow),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [W-1:0] trl(input int cnt, input int bits);
        logic [W-1:0] t;
        t = {cnt[23:0], bits[7:0]};
        return t;
    endfunction

    task automatic wait_done(input string tag);
        int k = 0;
        while (done !== 1'b1 && k < 64) begin
            cyc();
            k++;
        end
        chk(tag, done, 1);
    endtask

    task automatic end_pulse();
        end_sig = 1'b1;
        cyc();
        end_sig = 1'b0;
    endtask

    // Output monitor: sampled on the falling edge, away from the register updates
    always @(negedge clock) begin
        logic [W-1:0] e;
        if (!reset && push_fout) begin
            push_cnt++;
            chk("push_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("push_data", fout_data, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w1;
        logic [W-1:0] w2;
        int p0;

        // ---------------- reset state ----------------
        cyc();
        chk("rst_dec_ready", dec_ready, 1);
        chk("rst_push", push_fout, 0);
        chk("rst_data", fout_data, 0);
        chk("rst_count", word_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        cyc();

        // ---------------- end_sig in IDLE, no data ----------------
        p0 = push_cnt;
`ifdef PACK_TRAILER_EN
        exp_q.push_back(trl(0, 0));
`endif
        end_pulse();
        chk("idle_end_busy", busy, 1);
        wait_done("idle_end_done");
`ifdef PACK_TRAILER_EN
        chk("idle_end_pushes", push_cnt - p0, 1);
`else
        chk("idle_end_pushes", push_cnt - p0, 0);
`endif
        cyc();
        chk("idle_end_done_width", done, 0);
        chk("idle_end_back_idle", busy, 0);

        // ---------------- 32 alternating bits ----------------
        for (int i = 0; i < 32; i++) begin
            dec_valid = 1'b1;
            dec_bit   = (i % 2 == 0);
            if (i == 31) exp_q.push_back(32'h5555_5555);
            cyc();
        end
        dec_valid = 1'b0;
        chk("alt_latency", push_fout, 1);
        cyc();
        chk("alt_count", word_count, 1);
        chk("alt_drained", exp_q.size(), 0);
        // Flush with no partial bits: no data word, only the optional trailer
        p0 = push_cnt;
`ifdef PACK_TRAILER_EN
        exp_q.push_back(trl(1, 32));
`endif
        end_pulse();
        wait_done("alt_flush_done");
`ifdef PACK_TRAILER_EN
        chk("alt_flush_pushes", push_cnt - p0, 1);
`else
        chk("alt_flush_pushes", push_cnt - p0, 0);
`endif
        cyc();
        chk("count_clear_after_done", word_count, 0);

        // ---------------- five 1s then end_sig ----------------
        for (int i = 0; i < 5; i++) begin
            dec_valid = 1'b1;
            dec_bit   = 1'b1;
            cyc();
        end
        dec_valid = 1'b0;
        exp_q.push_back(32'h0000_001F);
`ifdef PACK_TRAILER_EN
        exp_q.push_back(trl(1, 5));
`endif
        end_pulse();
        chk("partial_ready_in_flush", dec_ready, 0);
        wait_done("partial_done");
        chk("partial_sent_before_done", exp_q.size(), 0);
        cyc();

        // ---------------- backpressure and overflow ----------------
        fout_full = 1'b1;
        w1 = '0;
        w2 = '0;
        for (int i = 0; i < 64; i++) begin
            dec_valid = 1'b1;
            dec_bit   = (i % 3 == 0);
            if (i < 32) w1[i] = dec_bit;
            else if (i < 63) w2[i-32] = dec_bit;
            if (i == 62) chk("bp_ready_bit63", dec_ready, 1);
            if (i == 63) chk("bp_ready_bit64", dec_ready, 0);
            cyc();
        end
        dec_valid = 1'b0;
        chk("bp_overflow", overflow, 1);
        chk("bp_no_push_full", push_fout, 0);
        exp_q.push_back(w1);
        fout_full = 1'b0;
        cyc();
        chk("bp_ready_back", dec_ready, 1);
        chk("bp_count", word_count, 1);
        exp_q.push_back(w2);
`ifdef PACK_TRAILER_EN
        exp_q.push_back(trl(2, 31));
`endif
        end_pulse();
        wait_done("bp_done");
        chk("bp_overflow_sticky", overflow, 1);
        cyc();

        // ---------------- reset mid-word ----------------
        p0 = push_cnt;
        for (int i = 0; i < 10; i++) begin
            dec_valid = 1'b1;
            dec_bit   = 1'b0;
            cyc();
        end
        dec_valid = 1'b0;
        reset = 1'b1;
        cyc();
        chk("mid_rst_ready", dec_ready, 1);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_push", push_fout, 0);
        reset = 1'b0;
        cyc();
        chk("mid_rst_no_push", push_cnt - p0, 0);
        for (int i = 0; i < 32; i++) begin
            dec_valid = 1'b1;
            dec_bit   = 1'b1;
            if (i == 31) exp_q.push_back(32'hFFFF_FFFF);
            cyc();
        end
        dec_valid = 1'b0;
        chk("mid_rst_latency", push_fout, 1);
        cyc();
`ifdef PACK_TRAILER_EN
        exp_q.push_back(trl(1, 32));
`endif
        end_pulse();
        wait_done("mid_rst_done");
        cyc();

        // ---------------- end_sig with the 32nd bit ----------------
        p0 = push_cnt;
        for (int i = 0; i < 32; i++) begin
            dec_valid = 1'b1;
            dec_bit   = 1'b1;
            if (i == 31) begin
                end_sig = 1'b1;
                exp_q.push_back(32'hFFFF_FFFF);
`ifdef PACK_TRAILER_EN
                exp_q.push_back(trl(1, 32));
`endif
            end
            cyc();
        end
        dec_valid = 1'b0;
        end_sig   = 1'b0;
        // end_sig during FLUSH must be ignored
        end_pulse();
        wait_done("coinc_done");
`ifdef PACK_TRAILER_EN
        chk("coinc_pushes", push_cnt - p0, 2);
`else
        chk("coinc_pushes", push_cnt - p0, 1);
`endif
        cyc();
        cyc();
        chk("final_idle", busy, 0);
        chk("final_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ed_result_packer.md
Name: ed_result_packer

Overview:
- Downstream neighbour of the energy-detection control unit and its decision-result register.
- Consumes the serial stream of 1-bit detection decisions (energy window above/below threshold).
- Packs the decisions LSB-first into WORD_W-bit words and pushes them into the output FIFO (fout) for readout.
- On end of a detection run, flushes any partial word zero-padded and signals completion.

Parameters:
- WORD_W, 32, packed word width; must be at least 16.
- CNT_W, 16, width of the data-word counter.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- dec_valid  input  1  decision bit present this cycle.
- dec_bit  input  1  decision value (1 = energy above threshold).
- dec_ready  output  1  packer can accept a decision this cycle.
- end_sig  input  1  one-cycle pulse marking end of detection run; triggers flush.
- fout_full  input  1  output FIFO full.
- push_fout  output  1  write strobe to output FIFO.
- fout_data  output  WORD_W  word written to output FIFO.
- word_count  output  CNT_W  data words pushed since reset or last done.
- overflow  output  1  sticky: a decision was offered while dec_ready=0.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse when flush is complete.

Behaviour:
- Reset values: all outputs 0 except dec_ready=1. Shift register, bit counter (bit_cnt) and hold register are cleared.
- Datapath:
  - shift register plus one hold register (hold_data, hold_valid).
  - Accepted bit k of a word lands at bit position k (LSB first).
  - Accept condition: dec_valid & dec_ready.
- Word completion:
  - When bit_cnt = WORD_W-1 and a bit is accepted, the completed word (including that bit) moves to hold on the next edge.
  - hold_valid=1 and bit_cnt=0 on that edge.
- dec_ready = !(bit_cnt == WORD_W-1 && hold_valid) && state is not FLUSH/TRAILER/DONE. It depends only on registers.
- Output FIFO handshake:
  - push_fout = hold_valid & !fout_full (combinational); fout_data = hold_data.
  - On a push edge, hold_valid clears unless a new word loads in the same cycle (load wins; hold_valid stays 1).
  - Latency: last bit accepted at cycle t gives push_fout at t+1 if fout_full=0.
- Overflow: dec_valid=1 while dec_ready=0 drops the bit and sets overflow. overflow stays set until reset.
- word_count increments on every data-word push and wraps at 2^CNT_W. It clears on the cycle done is asserted (after done is sampled). Trailer pushes are not counted.
- FSM states: IDLE, FILL, FLUSH, TRAILER (with the macro only), DONE.
  - IDLE→FILL on the first accepted bit.
  - IDLE/FILL→FLUSH on end_sig.
  - FLUSH: if bit_cnt>0, waits for hold to be free (or being pushed), then loads the zero-padded partial word into hold. It then waits until hold is empty and goes to TRAILER or DONE.
  - DONE: asserts done for 1 cycle, then →IDLE.
- Boundary conditions:
  - end_sig in the same cycle as an accepted bit: the bit is included in the flush.
  - If that bit completes a word, no extra partial word is pushed.
  - end_sig while in FLUSH, TRAILER or DONE is ignored.
  - end_sig in IDLE with bit_cnt=0: no data push; done pulses.
  - Reset mid-operation discards the partial word and the hold contents; no push.

Optional Feature:
- Macro: PACK_TRAILER_EN.
- Defined: after the flush empties, TRAILER pushes one extra word through hold using the same handshake.
  - bits[7:0] = valid bits in the last data word (1..WORD_W, or 0 if no data word).
  - bits[WORD_W-1:8] = word_count, truncated or zero-extended to fit.
  - done pulses after the trailer push.
- Undefined: the TRAILER state is absent; FLUSH goes directly to DONE.

Test Plan (WORD_W=32):
1. 32 bits alternating 1,0,1,… with fout_full=0 → one push of 0x55555555, one cycle after the 32nd bit; word_count=1.
2. Five 1-bits then end_sig → push 0x0000001F, then done pulse.
   - With PACK_TRAILER_EN: a second push of 0x00000105 before done.
3. fout_full=1, offer 64 consecutive bits → the 32nd bit fills hold, dec_ready drops after bit 63, bit 64 is dropped, overflow=1.
   - Release fout_full → push of word 1, dec_ready returns to 1.
4. end_sig in IDLE with no bits → no data push, done pulses.
   - With trailer: a push of 0x00000000.
5. 10 bits then reset asserted for 1 cycle → no push, all outputs at reset values.
   - Then 32 bits of 1 → push of 0xFFFFFFFF.
6. end_sig coincident with the 32nd bit (all 1s) → single push of 0xFFFFFFFF, no partial word.
   - With trailer: 0x00000120.
